// File: rtl/idu_pkg.sv
// Shared types for the instruction decode stage: operation classes, immediate
// formats, RV32 major opcodes, the decoded-field bundle and the skid FSM states.
package idu_pkg;

  typedef enum logic [3:0] {
    OP_LUI     = 4'd0,
    OP_AUIPC   = 4'd1,
    OP_JAL     = 4'd2,
    OP_JALR    = 4'd3,
    OP_BRANCH  = 4'd4,
    OP_LOAD    = 4'd5,
    OP_STORE   = 4'd6,
    OP_OPIMM   = 4'd7,
    OP_OP      = 4'd8,
    OP_SYSTEM  = 4'd9,
    OP_ILLEGAL = 4'd10
  } op_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Skid FSM: EMPTY has nothing to present, ONE holds the output register,
  // FULL additionally holds the skid register and blocks fetch.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  typedef struct packed {
    op_e         op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        illegal;
  } dec_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    dec_t        dec;
  } entry_t;

  // Sign-extended immediate assembly for each instruction format.
  function automatic logic [31:0] imm_gen(imm_fmt_e fmt, logic [31:0] inst);
    logic [31:0] imm;
    case (fmt)
      IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm = {inst[31:12], 12'b0};
      IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = 32'd0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/idu_decoder.sv
// Pure combinational RV32I/RV32E field decoder. Any illegal condition
// (unknown opcode, non-32-bit encoding, or an RV32E register index >= 16 in a
// field the instruction actually uses) reports op=ILLEGAL with a zero immediate.
module idu_decoder
  import idu_pkg::*;
#(
  parameter int RVE = 1
) (
  input  logic [31:0] inst,
  output dec_t        dec
);

  op_e      op_raw;
  imm_fmt_e fmt;
  logic     use_rd;
  logic     use_rs1;
  logic     use_rs2;
  logic     unknown;
  logic     rve_bad;
  logic     illegal;

  // Classify the major opcode and record which register fields it reads/writes.
  always_comb begin
    op_raw  = OP_ILLEGAL;
    fmt     = IMM_NONE;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    unknown = 1'b0;
    case (inst[6:0])
      OPC_LUI:    begin op_raw = OP_LUI;    fmt = IMM_U; use_rd = 1'b1; end
      OPC_AUIPC:  begin op_raw = OP_AUIPC;  fmt = IMM_U; use_rd = 1'b1; end
      OPC_JAL:    begin op_raw = OP_JAL;    fmt = IMM_J; use_rd = 1'b1; end
      OPC_JALR:   begin op_raw = OP_JALR;   fmt = IMM_I; use_rd = 1'b1; use_rs1 = 1'b1; end
      OPC_BRANCH: begin op_raw = OP_BRANCH; fmt = IMM_B; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OPC_LOAD:   begin op_raw = OP_LOAD;   fmt = IMM_I; use_rd = 1'b1; use_rs1 = 1'b1; end
      OPC_STORE:  begin op_raw = OP_STORE;  fmt = IMM_S; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OPC_OPIMM:  begin op_raw = OP_OPIMM;  fmt = IMM_I; use_rd = 1'b1; use_rs1 = 1'b1; end
      OPC_OP:     begin op_raw = OP_OP;     use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OPC_SYSTEM: begin op_raw = OP_SYSTEM; fmt = IMM_I; use_rd = 1'b1; use_rs1 = 1'b1; end
      default:    unknown = 1'b1;
    endcase
  end

  // Combine illegal sources and produce the decoded bundle.
  always_comb begin
    rve_bad = (RVE != 0) && ((use_rd & inst[11]) | (use_rs1 & inst[19]) | (use_rs2 & inst[24]));
    illegal = unknown | (inst[1:0] != 2'b11) | rve_bad;

    dec          = '0;
    dec.op       = illegal ? OP_ILLEGAL : op_raw;
    dec.funct3   = inst[14:12];
    dec.funct7b5 = inst[30];
    dec.rs1      = inst[19:15];
    dec.rs2      = inst[24:20];
    dec.rd       = (op_raw == OP_BRANCH || op_raw == OP_STORE) ? 5'd0 : inst[11:7];
    dec.imm      = illegal ? 32'd0 : imm_gen(fmt, inst);
    dec.illegal  = illegal;
  end

endmodule

// File: rtl/idu_decode_stage.sv
// Decode stage between fetch and execute. Decode is combinational on in_inst and
// captured into a 2-entry registered skid buffer so in_ready is a flop output.
// Optional performance counters are built when IDU_PERF_CNT_EN is defined.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; a producer holding valid keeps its data stable until that edge, and the
// output side keeps out_* stable while out_valid is high and out_ready is low.
module idu_decode_stage
  import idu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RVE  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_inst,
  output logic [3:0]      out_op,
  output logic [2:0]      out_funct3,
  output logic            out_funct7b5,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal,
`ifdef IDU_PERF_CNT_EN
  output logic [63:0]     perf_decoded,
  output logic [63:0]     perf_stall,
`endif
  output logic [1:0]      dbg_state
);

  dec_t   dec;
  entry_t new_e;
  entry_t out_q, out_d;
  entry_t skid_q, skid_d;
  state_e state_q, state_d;
  logic   in_ready_q, in_ready_d;
  logic   accept;

  idu_decoder #(.RVE(RVE)) u_decoder (
    .inst (in_inst),
    .dec  (dec)
  );

  // Next-state and buffer load selection; flush overrides everything.
  always_comb begin
    accept     = in_valid & in_ready_q;
    new_e.pc   = in_pc;
    new_e.inst = in_inst;
    new_e.dec  = dec;
    state_d    = state_q;
    out_d      = out_q;
    skid_d     = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            out_d   = new_e;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && out_ready) begin
            out_d = new_e;
          end else if (accept) begin
            skid_d  = new_e;
            state_d = ST_FULL;
          end else if (out_ready) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            out_d   = skid_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    in_ready_d = (state_d != ST_FULL);
  end

  // State, ready and buffer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
      out_q      <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      out_q      <= out_d;
      skid_q     <= skid_d;
    end
  end

`ifdef IDU_PERF_CNT_EN
  logic [63:0] perf_decoded_q, perf_decoded_d;
  logic [63:0] perf_stall_q, perf_stall_d;

  // Handshake and stall counters; free-running, untouched by flush.
  always_comb begin
    perf_decoded_d = perf_decoded_q + 64'(out_valid & out_ready);
    perf_stall_d   = perf_stall_q + 64'(out_valid & ~out_ready);
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_decoded_q <= 64'd0;
      perf_stall_q   <= 64'd0;
    end else begin
      perf_decoded_q <= perf_decoded_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_decoded = perf_decoded_q;
  assign perf_stall   = perf_stall_q;
`endif

  assign in_ready     = in_ready_q;
  assign out_valid    = (state_q != ST_EMPTY);
  assign out_pc       = out_q.pc;
  assign out_inst     = out_q.inst;
  assign out_op       = out_q.dec.op;
  assign out_funct3   = out_q.dec.funct3;
  assign out_funct7b5 = out_q.dec.funct7b5;
  assign out_rs1      = out_q.dec.rs1;
  assign out_rs2      = out_q.dec.rs2;
  assign out_rd       = out_q.dec.rd;
  assign out_imm      = out_q.dec.imm;
  assign out_illegal  = out_q.dec.illegal;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_idu_decode_stage.sv
// Bench for idu_decode_stage: an RV32E instance and an RV32I instance share all
// inputs; a scoreboard queue holds hand-computed expected entries and a monitor
// compares them whenever the DUT presents out_valid.
module tb_idu_decode_stage;
  import idu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_pc, in_inst;

  logic        in_ready_e, out_valid_e, f7b5_e, ill_e;
  logic [31:0] out_pc_e, out_inst_e, imm_e;
  logic [3:0]  op_e_o;
  logic [2:0]  f3_e;
  logic [4:0]  rs1_e, rs2_e, rd_e;
  logic [1:0]  dbg_e;

  logic        in_ready_i, out_valid_i, f7b5_i, ill_i;
  logic [31:0] out_pc_i, out_inst_i, imm_i;
  logic [3:0]  op_i_o;
  logic [2:0]  f3_i;
  logic [4:0]  rs1_i, rs2_i, rd_i;
  logic [1:0]  dbg_i;
`ifdef IDU_PERF_CNT_EN
  logic [63:0] pd_e, ps_e, pd_i, ps_i;
`endif

  // clock / reset
  always #5 clk = ~clk;

  idu_decode_stage #(.XLEN(32), .RVE(1)) dut_e (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_e),
    .in_pc(in_pc), .in_inst(in_inst), .out_valid(out_valid_e), .out_ready(out_ready),
    .out_pc(out_pc_e), .out_inst(out_inst_e), .out_op(op_e_o), .out_funct3(f3_e),
    .out_funct7b5(f7b5_e), .out_rs1(rs1_e), .out_rs2(rs2_e), .out_rd(rd_e),
    .out_imm(imm_e), .out_illegal(ill_e),
`ifdef IDU_PERF_CNT_EN
    .perf_decoded(pd_e), .perf_stall(ps_e),
`endif
    .dbg_state(dbg_e)
  );

  idu_decode_stage #(.XLEN(32), .RVE(0)) dut_i (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_i),
    .in_pc(in_pc), .in_inst(in_inst), .out_valid(out_valid_i), .out_ready(out_ready),
    .out_pc(out_pc_i), .out_inst(out_inst_i), .out_op(op_i_o), .out_funct3(f3_i),
    .out_funct7b5(f7b5_i), .out_rs1(rs1_i), .out_rs2(rs2_i), .out_rd(rd_i),
    .out_imm(imm_i), .out_illegal(ill_i),
`ifdef IDU_PERF_CNT_EN
    .perf_decoded(pd_i), .perf_stall(ps_i),
`endif
    .dbg_state(dbg_i)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [3:0]  op_e;
    logic [3:0]  op_i;
    logic        ill_e;
    logic        ill_i;
    logic [2:0]  f3;
    logic        f7b5;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%08h required 0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] inst,
                              input op_e ope, input op_e opi, input logic ille,
                              input logic illi, input logic [2:0] f3, input logic f7b5,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic [31:0] imm);
    exp_t e;
    e.pc = pc; e.inst = inst; e.op_e = ope; e.op_i = opi; e.ill_e = ille; e.ill_i = illi;
    e.f3 = f3; e.f7b5 = f7b5; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.imm = imm;
    return e;
  endfunction

  task automatic check_entry(input exp_t e);
    chk("pc",        out_pc_e,        e.pc);
    chk("inst",      out_inst_e,      e.inst);
    chk("op_rve",    32'(op_e_o),     32'(e.op_e));
    chk("illeg_rve", 32'(ill_e),      32'(e.ill_e));
    chk("funct3",    32'(f3_e),       32'(e.f3));
    chk("funct7b5",  32'(f7b5_e),     32'(e.f7b5));
    chk("rs1",       32'(rs1_e),      32'(e.rs1));
    chk("rs2",       32'(rs2_e),      32'(e.rs2));
    chk("rd",        32'(rd_e),       32'(e.rd));
    chk("imm",       imm_e,           e.imm);
    chk("pc_rvi",    out_pc_i,        e.pc);
    chk("op_rvi",    32'(op_i_o),     32'(e.op_i));
    chk("illeg_rvi", 32'(ill_i),      32'(e.ill_i));
    chk("valid_rvi", 32'(out_valid_i), 32'd1);
  endtask

  // scoreboard monitor: every presented output must match the queue head
  always @(negedge clk) begin
    if (!rst && out_valid_e) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_out: out_pc=0x%08h presented, required no output", out_pc_e);
      end else begin
        check_entry(exp_q[0]);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // driver: hold in_valid until the stage accepts, pushing the expectation on accept
  task automatic send(input exp_t e);
    bit accepted = 1'b0;
    in_valid = 1'b1;
    in_pc    = e.pc;
    in_inst  = e.inst;
    for (int k = 0; k < 50 && !accepted; k++) begin
      @(negedge clk);
      if (in_ready_e) begin
        accepted = 1'b1;
        exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
    end
    if (!accepted) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: pc=0x%08h not accepted in 50 cycles, required accept", e.pc);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    bit done = 1'b0;
    for (int k = 0; k < 50 && !done; k++) begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0) done = 1'b1;
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: %0d entries outstanding after 50 cycles, required 0", name, exp_q.size());
    end
  endtask

  task automatic check_idle(input string name);
    chk({name, "_out_valid"}, 32'(out_valid_e), 32'd0);
    chk({name, "_in_ready"},  32'(in_ready_e),  32'd1);
    chk({name, "_state"},     32'(dbg_e),       32'(ST_EMPTY));
  endtask

  exp_t e_addi, e_beq, e_addim1, e_lui, e_sw, e_jal, e_add16, e_zero;

  initial begin
    e_addi   = mk(32'h100, 32'h00500093, OP_OPIMM,   OP_OPIMM,  1'b0, 1'b0, 3'd0, 1'b0, 5'd0, 5'd5,  5'd1,  32'd5);
    e_beq    = mk(32'h104, 32'hFE000EE3, OP_BRANCH,  OP_BRANCH, 1'b0, 1'b0, 3'd0, 1'b1, 5'd0, 5'd0,  5'd0,  32'hFFFFFFFC);
    e_addim1 = mk(32'h108, 32'hFFF08193, OP_OPIMM,   OP_OPIMM,  1'b0, 1'b0, 3'd0, 1'b1, 5'd1, 5'd31, 5'd3,  32'hFFFFFFFF);
    e_lui    = mk(32'h200, 32'h123452B7, OP_LUI,     OP_LUI,    1'b0, 1'b0, 3'd5, 1'b0, 5'd8, 5'd3,  5'd5,  32'h12345000);
    e_sw     = mk(32'h204, 32'h0020A423, OP_STORE,   OP_STORE,  1'b0, 1'b0, 3'd2, 1'b0, 5'd1, 5'd2,  5'd0,  32'd8);
    e_jal    = mk(32'h208, 32'h010000EF, OP_JAL,     OP_JAL,    1'b0, 1'b0, 3'd0, 1'b0, 5'd0, 5'd16, 5'd1,  32'd16);
    e_add16  = mk(32'h400, 32'h01000833, OP_ILLEGAL, OP_OP,     1'b1, 1'b0, 3'd0, 1'b0, 5'd0, 5'd16, 5'd16, 32'd0);
    e_zero   = mk(32'h404, 32'h00000000, OP_ILLEGAL, OP_ILLEGAL,1'b1, 1'b1, 3'd0, 1'b0, 5'd0, 5'd0,  5'd0,  32'd0);

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_pc = 32'd0; in_inst = 32'd0;

    // reset state
    #12;
    check_idle("reset");
    chk("reset_out_pc",  out_pc_e,   32'd0);
    chk("reset_out_imm", imm_e,      32'd0);
    chk("reset_out_inst", out_inst_e, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // single instructions with out_ready high; output one cycle after accept
    send(e_addi);
    chk("latency_valid", 32'(out_valid_e), 32'd1);
    wait_drain("drain_addi");
    send(e_beq);
    send(e_addim1);
    wait_drain("drain_branch");

    // backpressure: A in output, B in skid, C waits at the input
    out_ready = 1'b0;
    send(e_lui);
    send(e_sw);
    chk("full_state",    32'(dbg_e),      32'(ST_FULL));
    chk("full_in_ready", 32'(in_ready_e), 32'd0);
    fork
      send(e_jal);
    join_none
    repeat (3) @(posedge clk);
    #1;
    chk("full_hold_state", 32'(dbg_e),      32'(ST_FULL));
    chk("full_hold_ready", 32'(in_ready_e), 32'd0);
    chk("full_hold_pc",    out_pc_e,        32'h200);
    out_ready = 1'b1;
    wait_drain("drain_skid");
    repeat (2) @(posedge clk);
    #1;

    // flush while FULL discards both held entries
    out_ready = 1'b0;
    send(e_addi);
    send(e_beq);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    exp_q.delete();
    check_idle("flush_full");

    // flush in ONE with an input presented: the input is discarded too
    send(e_addim1);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_pc    = 32'h30C;
    in_inst  = 32'h0020A423;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    check_idle("flush_one");
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // RV32E register limit and illegal encodings
    send(e_add16);
    send(e_zero);
    wait_drain("drain_illegal");

    // asynchronous reset while FULL
    out_ready = 1'b0;
    send(e_lui);
    send(e_jal);
    #3;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check_idle("rst_full");
    chk("rst_full_pc",   out_pc_e,   32'd0);
    chk("rst_full_inst", out_inst_e, 32'd0);
    chk("rst_full_imm",  imm_e,      32'd0);
    chk("rst_full_rd",   32'(rd_e),  32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    send(e_sw);
    wait_drain("drain_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
